// File: rtl/wb_gpio_irq.sv
//------------------------------------------------------------------------------
// wb_gpio_irq
// Wishbone-classic GPIO peripheral with per-pin edge interrupts.
// It has configurable width, input synchronisers, and atomic SET/CLR of
// the output register. It raises a level interrupt toward the CPU
// interrupt controller.
//
// Ports
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   wb_*                   Wishbone-classic slave (3-bit word address)
//   gpio_i                 asynchronous pad inputs
//   gpio_o / gpio_dir_o    output data / per-pin drive enable
//   irq_o                  level interrupt: |(IRQ_PEND & IRQ_EN), registered
//
// Register map (word address)
//   0 DATA  1 DIR  2 SET  3 CLR  4 IRQ_EN  5 IRQ_EDGE  6 IRQ_PEND(W1C)  7 OUT
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module wb_gpio_irq #(
    parameter int unsigned GPIO_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [2:0]            wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  wb_rty_o,
    input  logic [GPIO_WIDTH-1:0] gpio_i,
    output logic [GPIO_WIDTH-1:0] gpio_o,
    output logic [GPIO_WIDTH-1:0] gpio_dir_o,
    output logic                  irq_o
);

    localparam int unsigned W  = GPIO_WIDTH;
    localparam int unsigned DW = 32;

    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_SET  = 3'd2;
    localparam logic [2:0] A_CLR  = 3'd3;
    localparam logic [2:0] A_EN   = 3'd4;
    localparam logic [2:0] A_EDGE = 3'd5;
    localparam logic [2:0] A_PEND = 3'd6;
    localparam logic [2:0] A_OUT  = 3'd7;

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]  prev_q;
    logic [W-1:0]  irq_en_q;
    logic [W-1:0]  irq_edge_q;
    logic [W-1:0]  irq_pend_q;

    logic          req_c;
    logic          wr_c;
    logic [W-1:0]  wmask_c;
    logic [W-1:0]  wdata_c;
    logic [W-1:0]  sync_c;
    logic [W-1:0]  hit_c;
    logic [W-1:0]  w1c_c;
    logic [DW-1:0] rdata_c;
    logic          unused_c;

    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    // Data bits above GPIO_WIDTH are dropped on purpose.
    assign unused_c = &{1'b0, wb_dat_i};

    // A new request is accepted only while no ack is outstanding.
    assign req_c = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_c  = req_c & wb_we_i;

    // Per-pin write mask from the byte enables.
    for (genvar g = 0; g < W; g++) begin : g_lane
        assign wmask_c[g] = wb_sel_i[g/8];
    end
    assign wdata_c = wb_dat_i[W-1:0] & wmask_c;

    // Selected-edge detect on every pin, independent of direction or enable.
    assign sync_c = sync_q[SYNC_STAGES-1];
    assign hit_c  = (irq_edge_q & sync_c & ~prev_q) | (~irq_edge_q & ~sync_c & prev_q);
    assign w1c_c  = (wr_c && wb_adr_i == A_PEND) ? wdata_c : '0;

    // Read mux; write-only and unused bits return zero.
    always_comb begin
        rdata_c = '0;
        case (wb_adr_i)
            A_DATA:  rdata_c = DW'(sync_c);
            A_DIR:   rdata_c = DW'(gpio_dir_o);
            A_EN:    rdata_c = DW'(irq_en_q);
            A_EDGE:  rdata_c = DW'(irq_edge_q);
            A_PEND:  rdata_c = DW'(irq_pend_q);
            A_OUT:   rdata_c = DW'(gpio_o);
            default: rdata_c = '0;
        endcase
    end

    // Bus slave: ack, read data and register writes share one edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wb_ack_o   <= 1'b0;
            wb_dat_o   <= '0;
            gpio_o     <= '0;
            gpio_dir_o <= '0;
            irq_en_q   <= '0;
            irq_edge_q <= '0;
        end else begin
            wb_ack_o <= req_c;
            if (req_c) begin
                wb_dat_o <= rdata_c;
            end
            if (wr_c) begin
                case (wb_adr_i)
                    A_DATA:  gpio_o     <= (gpio_o & ~wmask_c) | wdata_c;
                    A_DIR:   gpio_dir_o <= (gpio_dir_o & ~wmask_c) | wdata_c;
                    A_SET:   gpio_o     <= gpio_o | wdata_c;
                    A_CLR:   gpio_o     <= gpio_o & ~wdata_c;
                    A_EN:    irq_en_q   <= (irq_en_q & ~wmask_c) | wdata_c;
                    A_EDGE:  irq_edge_q <= (irq_edge_q & ~wmask_c) | wdata_c;
                    default: ;
                endcase
            end
        end
    end

    // Input synchroniser, edge history, pending latch and interrupt line.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q     <= '0;
            prev_q     <= '0;
            irq_pend_q <= '0;
            irq_o      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], gpio_i};
            prev_q     <= sync_c;
            // A fresh edge wins over a simultaneous write-one-to-clear.
            irq_pend_q <= (irq_pend_q & ~w1c_c) | hit_c;
            irq_o      <= |(irq_pend_q & irq_en_q);
        end
    end

endmodule

// File: tb/tb_wb_gpio_irq.sv
`timescale 1ns/1ps
module tb_wb_gpio_irq;

    localparam int unsigned W = 8;
    localparam int unsigned S = 2;

    logic          i_clk;
    logic          i_reset_n;
    logic [2:0]    wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic          wb_we_i;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic          wb_rty_o;
    logic [W-1:0]  gpio_i;
    logic [W-1:0]  gpio_o;
    logic [W-1:0]  gpio_dir_o;
    logic          irq_o;

    wb_gpio_irq #(.GPIO_WIDTH(W), .SYNC_STAGES(S)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .wb_adr_i   (wb_adr_i),
        .wb_dat_i   (wb_dat_i),
        .wb_sel_i   (wb_sel_i),
        .wb_we_i    (wb_we_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_rty_o   (wb_rty_o),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_dir_o (gpio_dir_o),
        .irq_o      (irq_o)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected bus response for one accepted request.
    typedef struct {
        logic        is_read;
        logic [2:0]  adr;
        logic [31:0] data;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;

    // Reference model: architectural register contents plus pad history.
    logic [W-1:0] m_out, m_dir, m_en, m_edge, m_pend;
    logic         m_irq, m_ack;
    logic [W-1:0] hist[$];   // hist[k] = pad value sampled k+1 edges ago

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_out = '0; m_dir = '0; m_en = '0; m_edge = '0; m_pend = '0;
        m_irq = 1'b0; m_ack = 1'b0;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back('0);
        sbq.delete();
    endfunction

    // Advance one clock: evaluate the model on the current inputs, then commit at the edge.
    task automatic step();
        logic [W-1:0] vis, old, mask, wd, hits, pad;
        logic [W-1:0] n_out, n_dir, n_en, n_edge, n_pend;
        logic [31:0]  rd;
        logic         req;
        exp_t         e;
        // Pads become visible S clocks after sampling; previous visible value one clock earlier.
        vis = hist[S-1];
        old = hist[S];
        pad = gpio_i;
        for (int i = 0; i < W; i++) begin
            mask[i] = wb_sel_i[i/8];
            hits[i] = m_edge[i] ? (vis[i] && !old[i]) : (!vis[i] && old[i]);
        end
        wd  = wb_dat_i[W-1:0] & mask;
        req = wb_cyc_i && wb_stb_i && !m_ack;
        n_out = m_out; n_dir = m_dir; n_en = m_en; n_edge = m_edge; n_pend = m_pend;
        case (wb_adr_i)
            3'd0:    rd = 32'(vis);
            3'd1:    rd = 32'(m_dir);
            3'd4:    rd = 32'(m_en);
            3'd5:    rd = 32'(m_edge);
            3'd6:    rd = 32'(m_pend);
            3'd7:    rd = 32'(m_out);
            default: rd = 32'd0;
        endcase
        if (req && wb_we_i) begin
            case (wb_adr_i)
                3'd0:    n_out  = (m_out & ~mask) | wd;
                3'd1:    n_dir  = (m_dir & ~mask) | wd;
                3'd2:    n_out  = m_out | wd;
                3'd3:    n_out  = m_out & ~wd;
                3'd4:    n_en   = (m_en & ~mask) | wd;
                3'd5:    n_edge = (m_edge & ~mask) | wd;
                3'd6:    n_pend = m_pend & ~wd;
                default: ;
            endcase
        end
        n_pend = n_pend | hits;
        e.is_read = !wb_we_i;
        e.adr     = wb_adr_i;
        e.data    = rd;
        @(posedge i_clk);
        m_irq = |(m_pend & m_en);
        m_out = n_out; m_dir = n_dir; m_en = n_en; m_edge = n_edge; m_pend = n_pend;
        m_ack = req;
        if (req) sbq.push_back(e);
        hist.push_front(pad);
        void'(hist.pop_back());
        #1;
    endtask

    task automatic bus_idle();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic bus_drive(input logic we, input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    endtask

    task automatic wb_write(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        bus_drive(1'b1, adr, dat, sel);
        step();
        bus_idle();
        step();
    endtask

    task automatic wb_read(input logic [2:0] adr);
        bus_drive(1'b0, adr, 32'd0, 4'hF);
        step();
        bus_idle();
        step();
    endtask

    // Hold reset (already asserted) for two edges and release between edges.
    task automatic finish_reset();
        bus_idle();
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard on every ack and tracks the pin outputs each cycle.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            check("ack", 32'(wb_ack_o), 32'(m_ack));
            if (wb_ack_o) begin
                if (sbq.size() == 0) begin
                    check("ack_without_request", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (e.is_read) check($sformatf("read_adr%0d", e.adr), wb_dat_o, e.data);
                end
            end
            check("gpio_o", 32'(gpio_o), 32'(m_out));
            check("gpio_dir_o", 32'(gpio_dir_o), 32'(m_dir));
            check("irq_o", 32'(irq_o), 32'(m_irq));
            check("err_rty", 32'({wb_err_o, wb_rty_o}), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset_n = 1'b0;
        gpio_i    = '0;
        wb_adr_i  = '0;
        wb_dat_i  = '0;
        wb_sel_i  = '0;
        bus_idle();
        model_reset();
        #2;
        finish_reset();

        // Reset state: every register reads zero, outputs quiet.
        check("reset_irq", 32'(irq_o), 32'd0);
        check("reset_dir", 32'(gpio_dir_o), 32'd0);
        for (int a = 0; a < 8; a++) wb_read(3'(a));

        // DATA load then atomic SET/CLR: A5 | 0A = AF, AF & ~81 = 2E.
        wb_write(3'd0, 32'h0000_00A5, 4'hF);
        wb_write(3'd2, 32'h0000_000A, 4'hF);
        wb_write(3'd3, 32'h0000_0081, 4'hF);
        wb_read(3'd7);
        check("set_clr_out", 32'(gpio_o), 32'h0000_002E);

        // Single byte lane write to DIR.
        wb_write(3'd1, 32'hFFFF_FFFF, 4'b0001);
        check("dir_lane0", 32'(gpio_dir_o), 32'h0000_00FF);
        wb_read(3'd1);

        // Rising edge on pin 0: pending after S+1 clocks, irq one clock later.
        wb_write(3'd5, 32'h1, 4'hF);
        wb_write(3'd4, 32'h1, 4'hF);
        gpio_i = 8'h01;
        step(); step();
        check("irq_before_pend", 32'(irq_o), 32'd0);
        step();
        check("irq_at_pend", 32'(irq_o), 32'd0);
        step();
        check("irq_after_pend", 32'(irq_o), 32'd1);
        wb_read(3'd0);
        wb_read(3'd6);
        wb_write(3'd6, 32'h1, 4'hF);
        check("irq_after_w1c", 32'(irq_o), 32'd0);

        // Falling edge on pin 3 coincident with its W1C: pending stays set.
        wb_write(3'd5, 32'h0, 4'hF);
        wb_write(3'd4, 32'h8, 4'hF);
        gpio_i = 8'h09;
        repeat (4) step();
        gpio_i = 8'h01;
        repeat (4) step();
        gpio_i = 8'h09;
        repeat (4) step();
        gpio_i = 8'h01;
        repeat (S) step();
        bus_drive(1'b1, 3'd6, 32'h8, 4'hF);
        step();
        bus_idle();
        step();
        check("set_beats_w1c_irq", 32'(irq_o), 32'd1);
        wb_read(3'd6);

        // Clearing IRQ_EN drops irq but keeps pending.
        wb_write(3'd4, 32'h0, 4'hF);
        check("en_clear_irq", 32'(irq_o), 32'd0);
        wb_read(3'd6);
        wb_write(3'd4, 32'h8, 4'hF);
        step();

        // Async reset between strobe and ack.
        check("pre_reset_irq", 32'(irq_o), 32'd1);
        bus_drive(1'b1, 3'd0, 32'h5A, 4'hF);
        #1;
        i_reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_a_ack", 32'(wb_ack_o), 32'd0);
        check("rst_a_gpio", 32'(gpio_o), 32'd0);
        check("rst_a_irq", 32'(irq_o), 32'd0);
        finish_reset();

        // Async reset while ack is high.
        wb_write(3'd2, 32'hFF, 4'hF);
        bus_drive(1'b0, 3'd7, 32'd0, 4'hF);
        step();
        check("pre_reset_ack", 32'(wb_ack_o), 32'd1);
        #1;
        i_reset_n = 1'b0;
        model_reset();
        #1;
        check("rst_b_ack", 32'(wb_ack_o), 32'd0);
        check("rst_b_gpio", 32'(gpio_o), 32'd0);
        finish_reset();

        // Randomised traffic with back-to-back strobes and pad activity.
        for (int n = 0; n < 600; n++) begin
            if (($urandom % 4) == 0) gpio_i = gpio_i ^ W'($urandom);
            if (!(wb_stb_i && !m_ack)) begin
                if (($urandom % 3) != 0)
                    bus_drive(1'($urandom), 3'($urandom), $urandom, 4'($urandom));
                else
                    bus_idle();
            end
            step();
        end
        bus_idle();
        repeat (3) step();
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
